// File: rtl/ifetch_unit.sv
// Instruction fetch stage: holds the PC, fetches from IROM over a req/ack handshake, and computes the next PC.
// Optional misaligned-target trap enabled by defining IFETCH_MISALIGN_TRAP_EN.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BOOT_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_c,
  input  logic        exec_done,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic [31:0] instret
`ifdef IFETCH_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam logic [1:0]  ST_BOOT = 2'd0;
  localparam logic [1:0]  ST_REQ  = 2'd1;
  localparam logic [1:0]  ST_HOLD = 2'd2;
`ifdef IFETCH_MISALIGN_TRAP_EN
  localparam logic [1:0]  ST_HALT = 2'd3;
`endif
  localparam logic [3:0]  BOOT_WAIT_C = 4'(BOOT_WAIT);
  localparam logic [31:0] NOP_INST    = 32'h0000_0013;

  logic [1:0]  state_q, state_d;
  logic [3:0]  boot_cnt_q, boot_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        inst_valid_q, inst_valid_d;
  logic [31:0] instret_q, instret_d;
  logic [31:0] npc;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        trap_q, trap_d;
`endif

  function automatic logic [31:0] calc_npc(input logic [1:0]  op,
                                           input logic        taken,
                                           input logic [31:0] cur_pc,
                                           input logic [31:0] offset,
                                           input logic [31:0] jalr_tgt);
    logic [31:0] res;
    case (op)
      2'b00:   res = cur_pc + 32'd4;
      2'b01:   res = cur_pc + offset;
      2'b10:   res = taken ? (cur_pc + offset) : (cur_pc + 32'd4);
      default: res = jalr_tgt & 32'hFFFF_FFFE;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    instret_d    = instret_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
    trap_d       = trap_q;
`endif
    npc          = calc_npc(npc_op, br_taken, pc_q, imm, alu_c);

    case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q == BOOT_WAIT_C) state_d = ST_REQ;
        else                           boot_cnt_d = boot_cnt_q + 4'd1;
      end
      ST_REQ: begin
        if (imem_ack) begin
          inst_d       = imem_rdata;
          inst_valid_d = 1'b1;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (exec_done) begin
          inst_valid_d = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
          // A misaligned target freezes the core without retiring the instruction.
          if (npc[1:0] != 2'b00) begin
            trap_d  = 1'b1;
            state_d = ST_HALT;
          end else begin
            pc_d      = npc;
            instret_d = instret_q + 32'd1;
            state_d   = ST_REQ;
          end
`else
          pc_d      = npc & 32'hFFFF_FFFC;
          instret_d = instret_q + 32'd1;
          state_d   = ST_REQ;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= 4'd0;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_valid_q <= 1'b0;
      instret_q    <= 32'd0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      trap_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      instret_q    <= instret_d;
`ifdef IFETCH_MISALIGN_TRAP_EN
      trap_q       <= trap_d;
`endif
    end
  end

  assign imem_req   = (state_q == ST_REQ);
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign pc         = pc_q;
  assign pc4        = pc_q + 32'd4;
  assign instret    = instret_q;
`ifdef IFETCH_MISALIGN_TRAP_EN
  assign misalign_trap = trap_q;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed cases plus randomized fetch/execute traffic
// against a transaction-level PC/instret/inst model.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          BOOT_WAIT = 2;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] imm = 32'd0;
  logic [31:0] alu_c = 32'd0;
  logic        exec_done = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instret;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc;
  logic [31:0] minstret;
  logic [31:0] minst;
  bit          halted = 1'b0;

  ifetch_unit #(.RESET_PC(RESET_PC), .BOOT_WAIT(BOOT_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .br_taken(br_taken), .imm(imm),
    .alu_c(alu_c), .exec_done(exec_done), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .pc(pc), .pc4(pc4), .instret(instret)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .misalign_trap(misalign_trap)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Next-PC rule stated directly as arithmetic on the architectural PC.
  function automatic logic [31:0] ref_npc(input logic [1:0] op, input logic br,
                                          input logic [31:0] im, input logic [31:0] alu,
                                          input logic [31:0] cur);
    if (op == 2'b11) return {alu[31:1], 1'b0};
    if (op == 2'b01 || (op == 2'b10 && br)) return cur + im;
    return cur + 32'd4;
  endfunction

  task automatic check_reset_outputs();
    check("rst_pc", pc, RESET_PC);
    check("rst_inst", inst, NOP);
    check("rst_valid", 32'(inst_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instret", instret, 32'd0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("rst_trap", 32'(misalign_trap), 32'd0);
`endif
  endtask

  // Called at a negedge with rst_n low; releases reset and checks the boot delay.
  task automatic boot_seq(input bit late_ack);
    rst_n = 1'b1;
    if (late_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
    end
    for (int i = 1; i <= BOOT_WAIT + 1; i++) begin
      @(negedge clk);
      check("boot_req", 32'(imem_req), 32'(i == BOOT_WAIT + 1));
      check("boot_inst", inst, NOP);
      check("boot_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack = 1'b0;
    check("boot_addr", imem_addr, RESET_PC);
    mpc      = RESET_PC;
    minstret = 32'd0;
    minst    = NOP;
    halted   = 1'b0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_wait", 32'(imem_req), 32'd1);
  endtask

  task automatic do_fetch(input int wcyc, input logic [31:0] word, input bit poke_exec);
    wait_req();
    check("req_addr", imem_addr, mpc);
    for (int i = 0; i < wcyc; i++) begin
      exec_done = poke_exec && ($urandom_range(0, 1) == 1);
      npc_op    = 2'($urandom_range(0, 3));
      imm       = $urandom;
      @(negedge clk);
      exec_done = 1'b0;
      check("req_hold", 32'(imem_req), 32'd1);
      check("req_addr_stable", imem_addr, mpc);
      check("req_pc", pc, mpc);
      check("req_instret", instret, minstret);
      check("req_valid", 32'(inst_valid), 32'd0);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    minst      = word;
    check("ack_valid", 32'(inst_valid), 32'd1);
    check("ack_inst", inst, word);
    check("ack_req", 32'(imem_req), 32'd0);
    check("pc4", pc4, mpc + 32'd4);
  endtask

  task automatic do_exec(input logic [1:0] op, input logic br, input logic [31:0] im,
                         input logic [31:0] alu, input int hold, input bit stray);
    logic [31:0] npc;
    for (int i = 0; i < hold; i++) begin
      imem_ack   = stray;
      imem_rdata = $urandom;
      @(negedge clk);
      imem_ack = 1'b0;
      check("hold_inst", inst, minst);
      check("hold_valid", 32'(inst_valid), 32'd1);
      check("hold_pc", pc, mpc);
      check("hold_req", 32'(imem_req), 32'd0);
      check("hold_instret", instret, minstret);
    end
    npc      = ref_npc(op, br, im, alu, mpc);
    npc_op   = op;
    br_taken = br;
    imm      = im;
    alu_c    = alu;
    exec_done = 1'b1;
    @(negedge clk);
    exec_done = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (npc[1:0] != 2'b00) begin
      check("trap_flag", 32'(misalign_trap), 32'd1);
      check("trap_pc", pc, mpc);
      check("trap_instret", instret, minstret);
      check("trap_req", 32'(imem_req), 32'd0);
      check("trap_valid", 32'(inst_valid), 32'd0);
      halted = 1'b1;
      return;
    end
    check("no_trap", 32'(misalign_trap), 32'd0);
`endif
    mpc      = {npc[31:2], 2'b00};
    minstret = minstret + 32'd1;
    check("exec_pc", pc, mpc);
    check("exec_instret", instret, minstret);
    check("exec_valid", 32'(inst_valid), 32'd0);
    check("exec_req", 32'(imem_req), 32'd1);
    check("exec_addr", imem_addr, mpc);
    check("exec_pc4", pc4, mpc + 32'd4);
  endtask

  initial begin
    logic [31:0] r_imm;
    logic [31:0] r_alu;
    logic [31:0] saved_pc;

    repeat (2) @(negedge clk);
    check_reset_outputs();
    boot_seq(1'b0);

    // Sequential fetch with three wait states.
    do_fetch(3, 32'h0010_0093, 1'b0);
    do_exec(2'b00, 1'b0, 32'd0, 32'd0, 1, 1'b0);
    check("seq_addr", imem_addr, 32'h0000_0004);
    check("seq_instret", instret, 32'd1);

    // Reach pc = 0x100, then a taken and a not-taken backward branch.
    do_fetch(0, $urandom, 1'b0);
    do_exec(2'b01, 1'b0, 32'h100 - mpc, 32'd0, 0, 1'b0);
    check("jal_pc", pc, 32'h0000_0100);
    do_fetch(1, $urandom, 1'b0);
    do_exec(2'b10, 1'b1, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    check("br_taken_pc", pc, 32'h0000_00F0);
    do_fetch(0, $urandom, 1'b0);
    do_exec(2'b01, 1'b0, 32'h0000_0010, 32'd0, 0, 1'b0);
    do_fetch(2, $urandom, 1'b0);
    do_exec(2'b10, 1'b0, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);
    check("br_not_taken_pc", pc, 32'h0000_0104);

    // Random traffic: variable memory latency, stray exec_done in REQ, stray ack in HOLD.
    for (int n = 0; n < 150; n++) begin
      r_imm = $urandom;
      r_alu = $urandom;
`ifdef IFETCH_MISALIGN_TRAP_EN
      r_imm = r_imm & 32'hFFFF_FFFC;
      r_alu = r_alu & 32'hFFFF_FFFC;
`endif
      do_fetch($urandom_range(0, 4), $urandom, 1'b1);
      do_exec(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r_imm, r_alu,
              $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // jalr to an odd address.
    do_fetch(1, $urandom, 1'b0);
    saved_pc = mpc;
    do_exec(2'b11, 1'b0, 32'd0, 32'h0000_2003, 0, 1'b0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    check("jalr_trap", 32'(misalign_trap), 32'd1);
    check("jalr_trap_pc", pc, saved_pc);
    for (int i = 0; i < 3; i++) begin
      exec_done = 1'b1;
      imem_ack  = 1'b1;
      @(negedge clk);
      check("halt_req", 32'(imem_req), 32'd0);
      check("halt_valid", 32'(inst_valid), 32'd0);
    end
    exec_done = 1'b0;
    imem_ack  = 1'b0;
`else
    check("jalr_align_pc", pc, 32'h0000_2000);
`endif

    // Plain reset, then reset asserted mid-request at pc = 0x40 with a late ack during boot.
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    boot_seq(1'b0);
    do_fetch(1, $urandom, 1'b0);
    do_exec(2'b01, 1'b0, 32'h40 - mpc, 32'd0, 0, 1'b0);
    check("pre_rst_addr", imem_addr, 32'h0000_0040);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    boot_seq(1'b1);
    do_fetch(0, 32'h0000_0513, 1'b0);
    check("refetch_inst", inst, 32'h0000_0513);
    do_exec(2'b00, 1'b0, 32'd0, 32'd0, 0, 1'b0);
    check("refetch_pc", pc, RESET_PC + 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
